cmp_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single unsigned magnitude comparer among NREQ requesters. It grants one request at a time, latches that request's operands, runs one comparison, and returns the registered one-hot result to the granted requester over a valid/ready handshake. It sits between the requester blocks and the one comparer instance, so the datapath needs only one comparer.

---
 rtl/cmp_arbiter_if.sv | 17 +
 rtl/cmp_arbiter.sv | 76 +++++++
 tb/tb_cmp_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if: requester-side bus of the shared comparer arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface cmp_arbiter_if #(parameter int WIDTH = 8, parameter int NREQ = 4);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*WIDTH-1:0]   req_a;
    logic [NREQ*WIDTH-1:0]   req_b;
    logic [NREQ-1:0]         rsp_valid;
    logic [NREQ-1:0]         rsp_ready;
    logic [2:0]              rsp_f;
    logic [$clog2(NREQ)-1:0] rsp_id;
    logic                    busy;
    modport master (output req_valid, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_f, rsp_id, busy);
    modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_f, rsp_id, busy);
endinterface

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter sharing one unsigned magnitude comparer among NREQ requesters.
// Each transaction is accepted in IDLE, compared in CMP, and its result is held in RSP until consumed.
module cmp_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    cmp_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, CMP, RSP} state_t;
    state_t           state_q;
    logic [IW-1:0]    ptr_q, id_q, rsp_id_q, gnt_idx, idx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       rsp_f_q, cmp_f;
    logic [NREQ-1:0]  gnt, rsp_valid_q;
    logic             found, busy_q;
    // First valid requester at or above ptr, wrapping around.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (found) gnt[gnt_idx] = 1'b1;
    end
    assign cmp_f         = (a_q > b_q) ? 3'b100 : (a_q < b_q) ? 3'b010 : 3'b001;
    assign bus.req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_f     = rsp_f_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = busy_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_f_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    a_q     <= bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                    b_q     <= bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                    id_q    <= gnt_idx;
                    ptr_q   <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= CMP;
                end
                CMP: begin
                    rsp_f_q     <= cmp_f;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= NREQ'(1) << id_q;
                    state_q     <= RSP;
                end
                RSP: if (bus.rsp_ready[id_q]) begin
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed and random stimulus checked cycle by cycle against a transaction-level model.
module tb_cmp_arbiter;
    localparam int W = 8;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    cmp_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
    cmp_arbiter #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int tests = 0;
    int fails = 0;
    // Model: phase 0 waiting for a grant, 1 comparing, 2 offering the result.
    int m_ptr = 0;
    int m_ph  = 0;
    int m_id  = 0;
    logic [2:0] m_f = 3'b000;
    int grants[$];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction
    function automatic logic [2:0] ucmp(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
    endfunction
    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask
    // Check one cycle at the falling edge, then advance the model across the rising edge.
    task automatic cyc();
        int g;
        @(negedge clk);
        #1;
        g = (m_ph == 0) ? pick() : -1;
        chk("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("busy", 32'(bus.busy), 32'(m_ph != 0));
        chk("rsp_valid", 32'(bus.rsp_valid), (m_ph == 2) ? (32'd1 << m_id) : 32'd0);
        if (m_ph == 2) begin
            chk("rsp_f", 32'(bus.rsp_f), 32'(m_f));
            chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
        end
        if (m_ph == 0 && g >= 0) begin
            m_id  = g;
            m_f   = ucmp(bus.req_a[g*W +: W], bus.req_b[g*W +: W]);
            m_ptr = (g + 1) % N;
            m_ph  = 1;
            grants.push_back(g);
        end else if (m_ph == 1) m_ph = 2;
        else if (m_ph == 2 && bus.rsp_ready[m_id]) m_ph = 0;
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;
        #2;
        chk("reset req_ready", 32'(bus.req_ready), 0);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset rsp_f", 32'(bus.rsp_f), 0);
        chk("reset rsp_id", 32'(bus.rsp_id), 0);
        chk("reset busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Unsigned compare: 0x7F < 0x80
        set_op(0, 8'h7F, 8'h80);
        bus.req_valid = 4'b0001;
        cyc();
        bus.req_valid = '0;
        repeat (3) cyc();
        // Equal, then greater
        set_op(2, 8'hFF, 8'hFF);
        bus.req_valid = 4'b0100;
        cyc();
        bus.req_valid = '0;
        repeat (3) cyc();
        set_op(3, 8'h01, 8'h00);
        bus.req_valid = 4'b1000;
        cyc();
        bus.req_valid = '0;
        repeat (3) cyc();
        chk("ptr wrap grants", 32'(grants.size()), 3);
        // Round-robin with everyone valid
        grants.delete();
        set_op(0, 8'h10, 8'h20);
        set_op(1, 8'h55, 8'h55);
        set_op(2, 8'hA0, 8'h0A);
        set_op(3, 8'h00, 8'hFF);
        bus.req_valid = 4'b1111;
        repeat (15) cyc();
        bus.req_valid = '0;
        chk("rr count", 32'(grants.size()), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr order", 32'(grants[i]), 32'(i % N));
        // Response stall with requester 0 waiting
        grants.delete();
        bus.rsp_ready = '0;
        bus.req_valid = 4'b0011;
        repeat (7) cyc();
        bus.rsp_ready = '1;
        repeat (3) cyc();
        bus.req_valid = '0;
        repeat (2) cyc();
        chk("stall grants", 32'(grants.size()), 2);
        if (grants.size() >= 2) begin
            chk("stall first", 32'(grants[0]), 1);
            chk("stall second", 32'(grants[1]), 0);
        end
        // Reset during CMP
        set_op(3, 8'h33, 8'h44);
        bus.req_valid = 4'b1000;
        cyc();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst rsp_valid", 32'(bus.rsp_valid), 0);
        chk("midrst rsp_f", 32'(bus.rsp_f), 0);
        chk("midrst busy", 32'(bus.busy), 0);
        chk("midrst req_ready", 32'(bus.req_ready), 0);
        m_ph  = 0;
        m_ptr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        grants.delete();
        bus.req_valid = 4'b1001;
        cyc();
        bus.req_valid = 4'b1000;
        repeat (6) cyc();
        bus.req_valid = '0;
        repeat (2) cyc();
        if (grants.size() >= 2) begin
            chk("postrst first", 32'(grants[0]), 0);
            chk("postrst second", 32'(grants[1]), 3);
        end else chk("postrst grants", 32'(grants.size()), 2);
        // Operands change right after acceptance
        set_op(2, 8'h10, 8'h20);
        bus.req_valid = 4'b0100;
        cyc();
        bus.req_valid = '0;
        set_op(2, 8'hFF, 8'h00);
        repeat (3) cyc();
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.req_valid = 4'($urandom);
            bus.req_a     = 32'($urandom);
            bus.req_b     = ($urandom_range(0, 3) == 0) ? bus.req_a : 32'($urandom);
            bus.rsp_ready = 4'($urandom) | (($urandom_range(0, 1) == 1) ? 4'hF : 4'h0);
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
